ir_key_ctrl: RTL and testbench
==============================

# ir_key_ctrl

Sequencing controller between the IR frame receiver and the CPU-side register interface. It reads each completed frame exactly once from the receiver and validates address and command. It classifies the frame as a new press or a held-key repeat, then queues key events in a small show-ahead FIFO for software to pop. It also tracks key-held status and FIFO overflow.

## Interface
- `REPEAT_WINDOW`, default 5_500_000: cycles (110 ms at 50 MHz) after an accepted frame during which an identical frame counts as a repeat. Range 1 to 2^24-1.
- `FIFO_DEPTH`, default 4: event FIFO depth. Power of two, 2 to 16.
- `ADDR_MATCH`, default 8'h00: required address byte when `ACCEPT_ANY`=0.
- `ACCEPT_ANY`, default 1: 1 disables the address filter.

Ports:
- `iCLK`  in  1: single clock for all logic.
- `iRST_n`  in  1: asynchronous, active-low reset.
- `iRX_READY`  in  1: frame-ready level from the receiver. It may stay high for many cycles per frame.
- `oRX_READ`  out  1: read strobe to the receiver. Combinational, high for exactly one cycle per frame.
- `iRX_DATA`  in  32: frame from the receiver. Valid the cycle after `oRX_READ`. Command is [23:16], inverted command is [31:24], address is [7:0].
- `iCPU_RD`  in  1: pop strobe.
- `oKEY_VALID`  out  1: FIFO not empty.
- `oKEY_CMD`  out  8: head entry command.
- `oKEY_ADDR`  out  8: head entry address.
- `oKEY_REPEAT`  out  1: head entry is a repeat.
- `oKEY_HELD`  out  1: a key is currently considered held.
- `oOVERFLOW`  out  1: sticky flag, set when an event was dropped because the FIFO was full.
- `iCLR_OVF`  in  1: clears `oOVERFLOW`.

## Operation
- `ready_d` is `iRX_READY` registered. `oRX_READ` = `iRX_READY & ~ready_d & (state==IDLE)`.
  - A rising edge seen outside IDLE is lost; the frame is dropped.
  - A level held high never causes a second read.
- FSM states: IDLE, CAPTURE, CHECK.
  - IDLE → CAPTURE on the `oRX_READ` cycle.
  - CAPTURE: latch `iRX_DATA` into `frame`; → CHECK.
  - CHECK: evaluate the frame, perform any push; → IDLE.
- Validity in CHECK: `frame[31:24]==~frame[23:16]` AND (`ACCEPT_ANY` or `frame[7:0]==ADDR_MATCH`). Invalid frames are discarded and have no effect on the timer or `last_code`.
- Repeat classification: `repeat = held_cnt!=0 && {addr,cmd}==last_code`.
- For every valid frame:
  - `last_code` <= {addr,cmd}.
  - `held_cnt` <= `REPEAT_WINDOW`.
  - A valid frame with a different code counts as a new press.
- `held_cnt` (24-bit) decrements by 1 per cycle while nonzero and saturates at 0. `oKEY_HELD` = (`held_cnt`!=0).
- Push rule for a valid frame:
  - A new press is always pushed with repeat=0.
  - Repeat handling depends on `IR_AUTOREPEAT_EN` (see Configuration).
- FIFO: `FIFO_DEPTH` entries of 17 bits {repeat, addr, cmd}, with read/write pointers plus a count.
  - Outputs show the head entry combinationally.
  - The pop happens on `iCPU_RD & oKEY_VALID`. `iCPU_RD` on an empty FIFO is ignored.
  - If full and no pop occurs in the same cycle, the push is dropped and `oOVERFLOW` is set.
  - A push and pop in the same cycle while full are both performed; the count is unchanged and no overflow occurs.
  - A push and pop in the same cycle while empty is impossible, because a pop requires valid.
- `iCLR_OVF` clears `oOVERFLOW`. If it coincides with a new overflow, set wins.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE, `held_cnt`=0, `last_code`=0, `ready_d`=0. Any in-flight frame is abandoned.
- Let edge E0 be the edge where `iRX_READY` first samples high.
  - `oRX_READ` is high during the cycle before E0. The receiver updates its data at E0.
  - E1 captures the frame. E2 performs the push.
  - `oKEY_VALID` is high after E2, i.e. 3 cycles after `iRX_READY` rises.
- A pop at edge Ep updates the head outputs and `oKEY_VALID` after Ep.
- `held_cnt` is loaded at E2 and reaches 0 `REPEAT_WINDOW` cycles later.
- Minimum frame spacing handled without loss: 3 cycles.

## Configuration
- `IR_AUTOREPEAT_EN` defined: repeat frames are pushed with repeat=1, one event per repeat frame.
- `IR_AUTOREPEAT_EN` undefined: repeat frames are not pushed; they only refresh `held_cnt`. `oKEY_REPEAT` is tied to 0 and the FIFO width is 16 bits.

## Test plan
- Valid frame 32'hE31C_FF00 with ready held high for 50 cycles → exactly one `oRX_READ` pulse; `oKEY_VALID` 3 cycles after the rise; cmd=8'h1C, addr=8'h00, repeat=0.
- Same frame sent again 1000 cycles later → with `IR_AUTOREPEAT_EN`, a second entry with repeat=1. Without it, no second entry and `oKEY_HELD` stays 1.
- Corrupt frame 32'hE21C_FF00 (inverted-command mismatch) → no push, `oKEY_HELD` unchanged; the next valid frame is treated as a new press.
- `FIFO_DEPTH`=4: five distinct frames with no pops → 4 entries, `oOVERFLOW`=1. Then pop while a 6th frame pushes in the same cycle → count stays 4, no new drop; `iCLR_OVF` → 0.
- `REPEAT_WINDOW`=100: second identical frame 150 cycles after the first → repeat=0, `oKEY_HELD` falls at cycle 100 and rises again.
- Assert `iRST_n` low during CAPTURE → all outputs 0 and FIFO empty; after release, the next frame is decoded normally.

Source files
------------

// File: rtl/ir_key_ctrl.sv
// IR key controller: reads each receiver frame once, validates it, classifies press/repeat
// and queues key events in a show-ahead FIFO. Optional macro IR_AUTOREPEAT_EN queues repeats too.
module ir_key_ctrl #(
    parameter int unsigned REPEAT_WINDOW = 5_500_000,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter logic [7:0]  ADDR_MATCH    = 8'h00,
    parameter bit          ACCEPT_ANY    = 1'b1
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iRX_READY,
    output logic        oRX_READ,
    input  logic [31:0] iRX_DATA,
    input  logic        iCPU_RD,
    output logic        oKEY_VALID,
    output logic [7:0]  oKEY_CMD,
    output logic [7:0]  oKEY_ADDR,
    output logic        oKEY_REPEAT,
    output logic        oKEY_HELD,
    output logic        oOVERFLOW,
    input  logic        iCLR_OVF
);

`ifdef IR_AUTOREPEAT_EN
    localparam int unsigned ENTRY_W = 17;
    localparam bit          AUTO_C  = 1'b1;
`else
    localparam int unsigned ENTRY_W = 16;
    localparam bit          AUTO_C  = 1'b0;
`endif
    localparam int unsigned      PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [23:0]      WINDOW_C = 24'(REPEAT_WINDOW);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 ready_d_r;
    logic [23:0]          frame_r;        // {inv_cmd, cmd, addr}; the spare byte is never needed
    logic [23:0]          held_cnt_r;
    logic [15:0]          last_code_r;
    logic [ENTRY_W-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 overflow_r;

    logic                 capture_s;
    logic                 check_s;
    logic [7:0]           frame_cmd_s;
    logic [7:0]           frame_addr_s;
    logic [15:0]          frame_code_s;
    logic                 valid_s;
    logic                 repeat_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 wr_en_s;
    logic                 drop_s;
    logic [ENTRY_W-1:0]   push_entry_s;
    logic [ENTRY_W-1:0]   head_s;
    logic                 unused_bits_s;

    // Integrity check of the NEC-style inverted command byte.
    function automatic logic cmd_integrity_ok(input logic [7:0] cmd, input logic [7:0] inv_cmd);
        return (inv_cmd == ~cmd);
    endfunction

    assign unused_bits_s = ^iRX_DATA[15:8];

    assign oRX_READ     = iRX_READY & ~ready_d_r & (state_r == ST_IDLE);
    assign frame_cmd_s  = frame_r[15:8];
    assign frame_addr_s = frame_r[7:0];
    assign frame_code_s = {frame_addr_s, frame_cmd_s};
    assign valid_s      = cmd_integrity_ok(frame_cmd_s, frame_r[23:16]) &&
                          (ACCEPT_ANY || (frame_addr_s == ADDR_MATCH));
    assign repeat_s     = (held_cnt_r != 24'd0) && (frame_code_s == last_code_r);
    assign push_s       = check_s && valid_s && (!repeat_s || AUTO_C);
    assign pop_s        = iCPU_RD && (count_r != {CNT_W{1'b0}});
    assign full_s       = (count_r == DEPTH_C);
    assign wr_en_s      = push_s && (!full_s || pop_s);
    assign drop_s       = push_s && full_s && !pop_s;
    assign head_s       = fifo_mem_r[rd_ptr_r];

`ifdef IR_AUTOREPEAT_EN
    assign push_entry_s = {repeat_s, frame_code_s};
    assign oKEY_REPEAT  = head_s[16];
`else
    assign push_entry_s = frame_code_s;
    assign oKEY_REPEAT  = 1'b0;
`endif
    assign oKEY_VALID = (count_r != {CNT_W{1'b0}});
    assign oKEY_CMD   = head_s[7:0];
    assign oKEY_ADDR  = head_s[15:8];
    assign oKEY_HELD  = (held_cnt_r != 24'd0);
    assign oOVERFLOW  = overflow_r;

    // Sequencer next state and per-state strobes.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        check_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (oRX_READ) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                capture_s   = 1'b1;
                state_nxt_s = ST_CHECK;
            end
            ST_CHECK: begin
                check_s     = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, ready edge detector and captured frame.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_r   <= ST_IDLE;
            ready_d_r <= 1'b0;
            frame_r   <= 24'd0;
        end else begin
            state_r   <= state_nxt_s;
            ready_d_r <= iRX_READY;
            if (capture_s) begin
                frame_r <= {iRX_DATA[31:16], iRX_DATA[7:0]};
            end
        end
    end

    // Held-key window and last accepted code; invalid frames leave both untouched.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            held_cnt_r  <= 24'd0;
            last_code_r <= 16'd0;
        end else if (check_s && valid_s) begin
            held_cnt_r  <= WINDOW_C;
            last_code_r <= frame_code_s;
        end else if (held_cnt_r != 24'd0) begin
            held_cnt_r  <= held_cnt_r - 24'd1;
        end
    end

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                fifo_mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow; a new drop beats a simultaneous clear.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (iCLR_OVF) begin
            overflow_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Scoreboard bench for ir_key_ctrl: expected events are queued when frames are driven
// and compared against the FIFO head as software pops them.
module tb_ir_key_ctrl;
    localparam int         RW      = 100;
    localparam int         DEPTH   = 4;
    localparam logic [7:0] ADDR_M  = 8'h00;
    localparam bit         ACC_ANY = 1'b0;
`ifdef IR_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        iCLK      = 1'b0;
    logic        iRST_n    = 1'b0;
    logic        iRX_READY = 1'b0;
    logic [31:0] iRX_DATA  = 32'd0;
    logic        iCPU_RD   = 1'b0;
    logic        iCLR_OVF  = 1'b0;
    logic        oRX_READ;
    logic        oKEY_VALID;
    logic [7:0]  oKEY_CMD;
    logic [7:0]  oKEY_ADDR;
    logic        oKEY_REPEAT;
    logic        oKEY_HELD;
    logic        oOVERFLOW;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          rd_cnt = 0;
    int          m_e2   = -100000;
    logic [15:0] m_last = 16'h0000;
    bit          m_ovf  = 1'b0;
    logic [16:0] exp_q[$];

    ir_key_ctrl #(
        .REPEAT_WINDOW(RW),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_MATCH   (ADDR_M),
        .ACCEPT_ANY   (ACC_ANY)
    ) dut (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .iRX_READY  (iRX_READY),
        .oRX_READ   (oRX_READ),
        .iRX_DATA   (iRX_DATA),
        .iCPU_RD    (iCPU_RD),
        .oKEY_VALID (oKEY_VALID),
        .oKEY_CMD   (oKEY_CMD),
        .oKEY_ADDR  (oKEY_ADDR),
        .oKEY_REPEAT(oKEY_REPEAT),
        .oKEY_HELD  (oKEY_HELD),
        .oOVERFLOW  (oOVERFLOW),
        .iCLR_OVF   (iCLR_OVF)
    );

    // Free-running clock.
    always #5 iCLK = ~iCLK;

    // Edge counter used to time the held window.
    always @(posedge iCLK) cyc <= cyc + 1;

    // Count read strobes, sampled mid-cycle.
    always @(negedge iCLK) if (oRX_READ) rd_cnt <= rd_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic check_head(input string tag);
        chk({tag, "_valid"}, oKEY_VALID, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk({tag, "_cmd"},    oKEY_CMD,    exp_q[0][7:0]);
            chk({tag, "_addr"},   oKEY_ADDR,   exp_q[0][15:8]);
            chk({tag, "_repeat"}, oKEY_REPEAT, exp_q[0][16]);
        end
    endtask

    task automatic pop_key(input string tag);
        check_head(tag);
        iCPU_RD = 1'b1;
        step();
        iCPU_RD = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        chk({tag, "_after"}, oKEY_VALID, exp_q.size() != 0);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) pop_key(tag);
    endtask

    task automatic clear_ovf();
        iCLR_OVF = 1'b1;
        step();
        iCLR_OVF = 1'b0;
        m_ovf = 1'b0;
    endtask

    // Drives one frame like the receiver would; expects to start at posedge+1.
    task automatic send_frame(input logic [31:0] data, input int hold, input bit pop_e2);
        int          rd0;
        bit          v;
        bit          held_pre;
        bit          rp;
        bit          pu;
        bit          popped;
        logic [15:0] code;
        rd0 = rd_cnt;
        iRX_READY = 1'b1;
        step();
        iRX_DATA = data;
        step();
        iRX_DATA = 32'hA5A5_0F0F;
        popped = pop_e2 && (exp_q.size() != 0);
        if (popped) begin
            check_head("pop_e2");
            iCPU_RD = 1'b1;
        end
        step();
        iCPU_RD  = 1'b0;
        code     = {data[7:0], data[23:16]};
        v        = (data[31:24] == ~data[23:16]) && (ACC_ANY || (data[7:0] == ADDR_M));
        held_pre = (cyc - 1 - m_e2) < RW;
        rp       = v && held_pre && (code == m_last);
        pu       = v && (!rp || AUTO);
        if (popped) void'(exp_q.pop_front());
        if (pu) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({rp, code});
            else m_ovf = 1'b1;
        end
        if (v) begin
            m_last = code;
            m_e2   = cyc;
        end
        check_head("push");
        chk("held", oKEY_HELD, (cyc - m_e2) < RW);
        chk("ovf", oOVERFLOW, m_ovf);
        repeat (hold - 3) step();
        iRX_READY = 1'b0;
        step();
        chk("rd_pulses", rd_cnt - rd0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_read"},   oRX_READ,    1'b0);
        chk({tag, "_valid"},  oKEY_VALID,  1'b0);
        chk({tag, "_cmd"},    oKEY_CMD,    8'h00);
        chk({tag, "_addr"},   oKEY_ADDR,   8'h00);
        chk({tag, "_repeat"}, oKEY_REPEAT, 1'b0);
        chk({tag, "_held"},   oKEY_HELD,   1'b0);
        chk({tag, "_ovf"},    oOVERFLOW,   1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] c;
        repeat (3) step();
        check_reset_outputs("rst");
        iRST_n = 1'b1;
        step();

        // Long ready level: one read, event three cycles after the rise.
        send_frame(32'hE31C_FF00, 50, 1'b0);
        // Same code inside the window is a repeat.
        send_frame(32'hE31C_FF00, 3, 1'b0);
        chk("held_after_repeat", oKEY_HELD, 1'b1);
        drain("t_rep");
        pop_key("empty_pop");

        // Corrupt frame, then a different valid key, then a wrong address.
        send_frame(32'hE21C_FF00, 3, 1'b0);
        send_frame(32'hBF40_FF00, 3, 1'b0);
        send_frame(32'hE31C_FF5A, 3, 1'b0);
        drain("t_bad");

        // Window expiry: same code after the window is a fresh press.
        send_frame(32'hE31C_FF00, 3, 1'b0);
        begin
            int t0;
            t0 = m_e2;
            wait_until(t0 + RW - 1);
            chk("held_last_cycle", oKEY_HELD, 1'b1);
            step();
            chk("held_expired", oKEY_HELD, 1'b0);
            wait_until(t0 + 147);
        end
        send_frame(32'hE31C_FF00, 3, 1'b0);
        drain("t_exp");

        // Overflow with five distinct presses, then clear and push-with-pop while full.
        for (int k = 1; k <= 5; k++) begin
            c = 8'(k);
            send_frame({~c, c, 8'hFF, 8'h00}, 3, 1'b0);
        end
        chk("ovf_set", oOVERFLOW, 1'b1);
        clear_ovf();
        chk("ovf_clr", oOVERFLOW, 1'b0);
        c = 8'h06;
        send_frame({~c, c, 8'hFF, 8'h00}, 3, 1'b1);
        drain("t_ovf");

        // Reset while a frame is being captured.
        send_frame(32'hE31C_FF00, 3, 1'b0);
        iRX_READY = 1'b1;
        step();
        iRX_DATA  = 32'hE31C_FF00;
        iRX_READY = 1'b0;
        iRST_n    = 1'b0;
        #1;
        check_reset_outputs("rst_cap");
        exp_q.delete();
        m_ovf  = 1'b0;
        m_last = 16'h0000;
        m_e2   = -100000;
        step();
        step();
        iRST_n = 1'b1;
        step();
        send_frame(32'h7788_FF00, 3, 1'b0);
        drain("t_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
